q2n_serial_exec: RTL and testbench
==================================

// Module: q2n_serial_exec
// PURPOSE
//  Parametrised bit-serial execution unit for the next-generation Q2 core.
//  Holds the A, X and P registers and the carry flag F. Runs ALU operations
//  LSB-first through a 1-bit adder/NOR over WIDTH cycles. Accepts commands
//  from the sequencer by valid/ready handshake and handles front-panel
//  deposit and increment-P while idle.
// PARAMETERS
//  WIDTH  12  word width of A, X, P, operand and sw; legal range 4..32
// PORTS
//  clk        in   1      system clock; all state changes on rising edge
//  rst        in   1      asynchronous, active-high reset
//  op_valid   in   1      command present on op/operand
//  op_ready   out  1      unit idle; command accepted when op_valid&op_ready
//  op         in   3      0 LDA,1 LDX,2 ADD,3 NOR,4 ADX,5 SHR,6 INCP,7 JMP
//  operand    in   WIDTH  memory/data-bus word; sampled at accept only
//  done       out  1      one-cycle pulse; results valid in the same cycle
//  dep_sw     in   1      panel deposit switch, level; sw loads on rising edge
//  incp_sw    in   1      panel increment-P switch, level; rising edge acts
//  sw         in   WIDTH  panel switch word
//  a_out      out  WIDTH  accumulator A
//  x_out      out  WIDTH  index/shift register X
//  p_out      out  WIDTH  program counter P
//  f_out      out  1      carry flag F
// BEHAVIOUR
//  Reset: A=X=P=0, F=0, done=0, state IDLE (op_ready=1). Bit counter and
//   operand shift register cleared. Panel edge detectors reloaded with 0.
//   Reset mid-operation abandons it; no done pulse is issued.
//  States: IDLE, SHIFT, DONE. op_ready=1 only in IDLE.
//  Single-cycle ops (LDA, LDX, SHR, INCP, JMP): on accept, IDLE->DONE.
//   The register updates at that clock edge; done=1 on the next cycle.
//   LDA A=operand; LDX X=operand; JMP P=operand.
//   SHR {A,F} <= {F,A}>>1: A={F,A[W-1:1]}, F=A[0].
//   INCP P=P+1 mod 2^WIDTH; all-ones wraps to 0, F unchanged.
//  Serial ops (ADD, NOR, ADX): on accept, latch operand into shift reg S.
//   ADD/NOR: S<=operand. ADX: S<=A, destination X.
//   Clear carry c; enter SHIFT with counter=0.
//  SHIFT, each cycle: b = dst[0] op S[0] (ADD/ADX: sum with c; NOR: ~(d|s)).
//   dst <= {b, dst[W-1:1]}; S >>= 1; c <= carry out; counter++.
//   After the cycle with counter=WIDTH-1, go to DONE.
//   ADD/ADX: F=final carry. NOR: F unchanged.
//   Latency: accept at edge 0; done high during cycle WIDTH+1.
//   dst holds the full result when done is high.
//   Intermediate register values during SHIFT are visible but undefined
//   to consumers.
//  DONE: done=1 for exactly one cycle, then IDLE. op_ready=1 in the cycle
//   after done.
//  Panel: dep_sw/incp_sw rising edges are detected with a registered
//   previous value.
//   Edge in IDLE with no accepted command: dep A=sw; incp P=P+1 (wraps).
//   Both edges in the same cycle: apply both.
//   Edge while busy, or in the same cycle a command is accepted: discarded.
//   A discarded edge is not queued.
//  op_valid while not ready: ignored; op/operand need not be held.
// TESTING (WIDTH=12 unless noted)
//  ADD: LDA 0xFFF, then ADD 0x001 -> A=0x000, F=1, done 13 cycles after accept.
//  NOR: LDA 0x0F0, NOR 0x00F -> A=0xF00, F unchanged.
//   Then ADX with X=0x001 -> X=0xF01, F=0.
//  Wrap/SHR: JMP 0xFFF, INCP -> P=0x000.
//   SHR on A=0x001, F=1 -> A=0x800, F=1.
//  Reset mid-op: assert rst at SHIFT cycle 5 of ADD -> all outputs 0
//   immediately, no done; next LDA works normally.
//  Panel: dep_sw edge with sw=0xABC while ADD busy -> A unaffected.
//   Same edge when idle -> A=0xABC. incp_sw held high 10 cycles -> P+1 once.
//  WIDTH=16: ADD 0x8000+0x8000 -> A=0x0000, F=1, done 17 cycles after accept.

Source files
------------

// File: rtl/q2n_serial_exec.sv
`default_nettype none
// ============================================================================
//  Module   : q2n_serial_exec
//  Purpose  : Bit-serial execution unit for the Q2 core. Holds A, X, P and
//             the carry flag F; runs ADD/NOR/ADX LSB-first through a 1-bit
//             adder/NOR, executes the other ops in one cycle, and services
//             the front-panel deposit / increment-P switches while idle.
//  Revision : 1.0  initial release
// ============================================================================
module q2n_serial_exec #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             done,
  input  logic             dep_sw,
  input  logic             incp_sw,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] p_out,
  output logic             f_out
);

  localparam logic [2:0] c_OP_LDA  = 3'd0;
  localparam logic [2:0] c_OP_LDX  = 3'd1;
  localparam logic [2:0] c_OP_ADD  = 3'd2;
  localparam logic [2:0] c_OP_NOR  = 3'd3;
  localparam logic [2:0] c_OP_ADX  = 3'd4;
  localparam logic [2:0] c_OP_SHR  = 3'd5;
  localparam logic [2:0] c_OP_INCP = 3'd6;
  localparam logic [2:0] c_OP_JMP  = 3'd7;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_p;
  logic             r_f;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_dep_q;
  logic             r_incp_q;

  logic             w_accept;
  logic             w_serial;
  logic             w_last;
  logic             w_d;
  logic             w_sbit;
  logic             w_sum;
  logic             w_cout;
  logic             w_bit;
  logic             w_dep_edge;
  logic             w_incp_edge;

  assign w_serial    = (op == c_OP_ADD) || (op == c_OP_NOR) || (op == c_OP_ADX);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_dep_edge  = dep_sw & ~r_dep_q;
  assign w_incp_edge = incp_sw & ~r_incp_q;

  // ADX accumulates into X; every other serial op works on A
  assign w_d    = (r_op == c_OP_ADX) ? r_x[0] : r_a[0];
  assign w_sbit = r_s[0];
  assign w_sum  = w_d ^ w_sbit ^ r_c;
  assign w_cout = (w_d & w_sbit) | (r_c & (w_d ^ w_sbit));
  assign w_bit  = (r_op == c_OP_NOR) ? ~(w_d | w_sbit) : w_sum;

  assign a_out = r_a;
  assign x_out = r_x;
  assign p_out = r_p;
  assign f_out = r_f;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and done decode
  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_serial ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Architectural registers, serial datapath and panel actions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_x      <= '0;
      r_p      <= '0;
      r_f      <= 1'b0;
      r_s      <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_op     <= 3'd0;
      r_dep_q  <= 1'b0;
      r_incp_q <= 1'b0;
    end else begin
      r_dep_q  <= dep_sw;
      r_incp_q <= incp_sw;
      if (w_accept) begin
        r_op  <= op;
        r_c   <= 1'b0;
        r_cnt <= '0;
        case (op)
          c_OP_LDA:  r_a <= operand;
          c_OP_LDX:  r_x <= operand;
          c_OP_ADD:  r_s <= operand;
          c_OP_NOR:  r_s <= operand;
          c_OP_ADX:  r_s <= r_a;
          c_OP_SHR: begin
            r_a <= {r_f, r_a[WIDTH-1:1]};
            r_f <= r_a[0];
          end
          c_OP_INCP: r_p <= r_p + WIDTH'(1);
          c_OP_JMP:  r_p <= operand;
          default:   r_p <= r_p;
        endcase
      end else if (r_state == S_SHIFT) begin
        if (r_op == c_OP_ADX) begin
          r_x <= {w_bit, r_x[WIDTH-1:1]};
        end else begin
          r_a <= {w_bit, r_a[WIDTH-1:1]};
        end
        r_s   <= r_s >> 1;
        r_c   <= w_cout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last && (r_op != c_OP_NOR)) begin
          r_f <= w_cout;
        end
      end else if (r_state == S_IDLE) begin
        // Panel edges only act when idle and no command is taken this cycle
        if (w_dep_edge) begin
          r_a <= sw;
        end
        if (w_incp_edge) begin
          r_p <= r_p + WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_q2n_serial_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_q2n_serial_exec
//  Purpose  : Self-checking bench for q2n_serial_exec against a word-level
//             reference model (WIDTH=12 main instance, WIDTH=16 side check).
//  Revision : 1.0  initial release
// ============================================================================
module tb_q2n_serial_exec;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [11:0] operand;
  logic        done;
  logic        dep_sw;
  logic        incp_sw;
  logic [11:0] sw;
  logic [11:0] a_out;
  logic [11:0] x_out;
  logic [11:0] p_out;
  logic        f_out;

  logic        v16;
  logic        rdy16;
  logic [2:0]  op16;
  logic [15:0] opd16;
  logic        done16;
  logic [15:0] a16;
  logic [15:0] x16;
  logic [15:0] p16;
  logic        f16;

  int n_total = 0;
  int n_bad   = 0;

  logic [11:0] m_a;
  logic [11:0] m_x;
  logic [11:0] m_p;
  logic        m_f;

  q2n_serial_exec #(.WIDTH(12)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .operand(operand), .done(done), .dep_sw(dep_sw), .incp_sw(incp_sw), .sw(sw),
    .a_out(a_out), .x_out(x_out), .p_out(p_out), .f_out(f_out)
  );

  q2n_serial_exec #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .op_valid(v16), .op_ready(rdy16), .op(op16),
    .operand(opd16), .done(done16), .dep_sw(1'b0), .incp_sw(1'b0), .sw(16'h0),
    .a_out(a16), .x_out(x16), .p_out(p16), .f_out(f16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_a"}, 32'(a_out), 32'(m_a));
    chk({tag, "_x"}, 32'(x_out), 32'(m_x));
    chk({tag, "_p"}, 32'(p_out), 32'(m_p));
    chk({tag, "_f"}, 32'(f_out), 32'(m_f));
  endtask

  // Word-level effect of one command on the architectural state
  task automatic model_op(input logic [2:0] o, input logic [11:0] d, output int lat);
    logic [12:0] wide;
    logic        lsb;
    lat = 1;
    case (o)
      3'd0: m_a = d;
      3'd1: m_x = d;
      3'd2: begin wide = {1'b0, m_a} + {1'b0, d}; m_a = wide[11:0]; m_f = wide[12]; lat = 13; end
      3'd3: begin m_a = ~(m_a | d); lat = 13; end
      3'd4: begin wide = {1'b0, m_x} + {1'b0, m_a}; m_x = wide[11:0]; m_f = wide[12]; lat = 13; end
      3'd5: begin lsb = m_a[0]; m_a = (m_a >> 1) | (m_f ? 12'h800 : 12'h000); m_f = lsb; end
      3'd6: m_p = m_p + 12'd1;
      default: m_p = d;
    endcase
  endtask

  // dep_mode: 0 none, 1 dep edge together with accept, 2 dep edge while busy
  task automatic do_op(input logic [2:0] o, input logic [11:0] d, input int dep_mode);
    int lat;
    int exp_lat;
    int waitc;
    @(negedge clk);
    waitc = 0;
    while (!op_ready && waitc < 40) begin @(negedge clk); waitc++; end
    chk("ready_before_op", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op       = o;
    operand  = d;
    if (dep_mode == 1) begin dep_sw = 1'b1; sw = 12'($urandom); end
    model_op(o, d, exp_lat);
    @(posedge clk);
    #1;
    op_valid = 1'($urandom);
    op       = 3'($urandom);
    operand  = 12'($urandom);
    @(negedge clk);
    lat = 1;
    if (dep_mode == 2) begin dep_sw = 1'b1; sw = 12'hABC; end
    while (!done && lat < 40) begin
      op_valid = 1'($urandom);
      op       = 3'($urandom);
      operand  = 12'($urandom);
      @(negedge clk);
      lat++;
    end
    op_valid = 1'b0;
    dep_sw   = 1'b0;
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk_regs("result");
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after_done", 32'(op_ready), 32'd1);
  endtask

  // Idle panel action: raise the selected switches, hold, then release
  task automatic panel(input logic dep, input logic inc, input logic [11:0] val, input int hold);
    @(negedge clk);
    op_valid = 1'b0;
    dep_sw   = dep;
    incp_sw  = inc;
    sw       = val;
    if (dep) m_a = val;
    if (inc) m_p = m_p + 12'd1;
    for (int i = 0; i < hold; i++) @(negedge clk);
    chk_regs("panel_held");
    dep_sw  = 1'b0;
    incp_sw = 1'b0;
    sw      = 12'($urandom);
    @(negedge clk);
    @(negedge clk);
    chk_regs("panel_released");
  endtask

  task automatic do16(input logic [2:0] o, input logic [15:0] d, output int lat);
    @(negedge clk);
    v16   = 1'b1;
    op16  = o;
    opd16 = d;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!done16 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  initial begin
    int lat16;
    int rl;
    logic [2:0] ro;
    rst = 1'b1; op_valid = 1'b0; op = 3'd0; operand = 12'd0;
    dep_sw = 1'b0; incp_sw = 1'b0; sw = 12'd0;
    v16 = 1'b0; op16 = 3'd0; opd16 = 16'd0;
    m_a = 12'd0; m_x = 12'd0; m_p = 12'd0; m_f = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_regs("reset");
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ready", 32'(op_ready), 32'd1);
    rst = 1'b0;

    // Directed cases
    do_op(3'd0, 12'hFFF, 0);
    do_op(3'd2, 12'h001, 0);
    chk("add_wrap_a", 32'(a_out), 32'h000);
    chk("add_wrap_f", 32'(f_out), 32'd1);
    do_op(3'd0, 12'h0F0, 0);
    do_op(3'd3, 12'h00F, 0);
    chk("nor_a", 32'(a_out), 32'hF00);
    chk("nor_f_kept", 32'(f_out), 32'd1);
    do_op(3'd1, 12'h001, 0);
    do_op(3'd4, 12'h555, 0);
    chk("adx_x", 32'(x_out), 32'hF01);
    chk("adx_f", 32'(f_out), 32'd0);
    do_op(3'd7, 12'hFFF, 0);
    do_op(3'd6, 12'h000, 0);
    chk("incp_wrap", 32'(p_out), 32'h000);
    do_op(3'd0, 12'hFFF, 0);
    do_op(3'd2, 12'h001, 0);
    do_op(3'd0, 12'h001, 0);
    do_op(3'd5, 12'h000, 0);
    chk("shr_a", 32'(a_out), 32'h800);
    chk("shr_f", 32'(f_out), 32'd1);

    // Panel: discarded while busy and at accept, applied when idle
    do_op(3'd2, 12'h123, 2);
    do_op(3'd1, 12'h321, 1);
    panel(1'b1, 1'b0, 12'hABC, 1);
    chk("dep_idle", 32'(a_out), 32'hABC);
    panel(1'b0, 1'b1, 12'h000, 10);
    panel(1'b1, 1'b1, 12'h5A5, 3);

    // Reset in the middle of a serial op
    @(negedge clk);
    op_valid = 1'b1; op = 3'd2; operand = 12'h0FF;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_a = 12'd0; m_x = 12'd0; m_p = 12'd0; m_f = 1'b0;
    chk_regs("midop_reset");
    chk("midop_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rl = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (done) rl++; end
    chk("no_done_after_reset", 32'(rl), 32'd0);
    do_op(3'd0, 12'h3C3, 0);

    // Randomised commands with interleaved idle panel activity
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      do_op(ro, 12'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0)
        panel(1'($urandom), 1'($urandom), 12'($urandom), int'($urandom_range(1, 4)));
    end

    // WIDTH=16 carry-out case
    do16(3'd0, 16'h8000, lat16);
    chk("w16_lda_lat", 32'(lat16), 32'd1);
    do16(3'd2, 16'h8000, lat16);
    chk("w16_add_lat", 32'(lat16), 32'd17);
    chk("w16_add_a", 32'(a16), 32'h0000);
    chk("w16_add_f", 32'(f16), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
